// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle between the stall/flush sequencer (master) and the datapath (slave).
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic ihit;
  logic dhit;
  logic exmem_dreq;
  logic stall_lw;
  logic branch_taken;
  logic halt_mem;

  logic pc_en;
  logic pc_sel;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic memwb_flush;
  logic halt;
  logic err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  ihit, dhit, exmem_dreq, stall_lw, branch_taken, halt_mem,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output halt, err, stall_cnt, flush_cnt
  );

  modport slave (
    output ihit, dhit, exmem_dreq, stall_lw, branch_taken, halt_mem,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  halt, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables, halt drain, data-wait watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  pipeline_ctrl_if.master bus
);

  localparam int unsigned DRAIN_W = 4;
  localparam int unsigned WAIT_W  = 8;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, DWAIT, HALTING, HALTED} ctrlState_t;

  ctrlState_t         state, stateD;
  logic [DRAIN_W-1:0] drainCnt, drainD;
  logic [WAIT_W-1:0]  waitCnt, waitD;
  logic               errQ, errD;
  logic               haltQ, haltD;

  logic pcEn, pcSel, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidFlush, idexFlush, exmemFlush, memwbFlush;
  logic branchFire;
  logic dataWait;

  assign dataWait = bus.exmem_dreq & ~bus.dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      drainCnt <= '0;
      waitCnt  <= '0;
      errQ     <= 1'b0;
      haltQ    <= 1'b0;
    end else begin
      state    <= stateD;
      drainCnt <= drainD;
      waitCnt  <= waitD;
      errQ     <= errD;
      haltQ    <= haltD;
    end
  end

  always_comb begin
    stateD     = state;
    drainD     = drainCnt;
    waitD      = waitCnt;
    errD       = errQ;
    haltD      = haltQ;
    pcEn       = 1'b0;
    pcSel      = 1'b0;
    ifidEn     = 1'b0;
    idexEn     = 1'b0;
    exmemEn    = 1'b0;
    memwbEn    = 1'b0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    memwbFlush = 1'b0;
    branchFire = 1'b0;

    case (state)
      HALTED: begin
        haltD = 1'b1;
      end
      HALTING: begin
        // Bubble the front of the pipe while older instructions retire through WB
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        memwbEn    = 1'b1;
        ifidFlush  = 1'b1;
        idexFlush  = 1'b1;
        exmemFlush = 1'b1;
        if (drainCnt == DRAIN_LAST) begin
          stateD = HALTED;
          haltD  = 1'b1;
        end else begin
          drainD = drainCnt + DRAIN_W'(1);
        end
      end
      default: begin
        if (dataWait) begin
          stateD     = DWAIT;
          memwbEn    = 1'b1;
          memwbFlush = 1'b1;
          waitD      = (waitCnt == WAIT_LAST) ? waitCnt : waitCnt + WAIT_W'(1);
          if (waitD == WAIT_LAST) begin
            errD = 1'b1;
          end
        end else begin
          waitD  = '0;
          drainD = '0;
          stateD = bus.halt_mem ? HALTING : RUN;
          if (bus.branch_taken) begin
            pcEn       = 1'b1;
            pcSel      = 1'b1;
            ifidEn     = 1'b1;
            idexEn     = 1'b1;
            exmemEn    = 1'b1;
            memwbEn    = 1'b1;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            branchFire = 1'b1;
          end else if (bus.stall_lw) begin
            idexEn    = 1'b1;
            idexFlush = 1'b1;
            exmemEn   = 1'b1;
            memwbEn   = 1'b1;
          end else if (!bus.ihit) begin
            ifidEn    = 1'b1;
            ifidFlush = 1'b1;
            idexEn    = 1'b1;
            exmemEn   = 1'b1;
            memwbEn   = 1'b1;
          end else begin
            pcEn    = 1'b1;
            ifidEn  = 1'b1;
            idexEn  = 1'b1;
            exmemEn = 1'b1;
            memwbEn = 1'b1;
          end
        end
      end
    endcase
  end

  // Held in reset, every latch and the PC are frozen
  assign bus.pc_en       = nRST & pcEn;
  assign bus.pc_sel      = nRST & pcSel;
  assign bus.ifid_en     = nRST & ifidEn;
  assign bus.idex_en     = nRST & idexEn;
  assign bus.exmem_en    = nRST & exmemEn;
  assign bus.memwb_en    = nRST & memwbEn;
  assign bus.ifid_flush  = nRST & ifidFlush;
  assign bus.idex_flush  = nRST & idexFlush;
  assign bus.exmem_flush = nRST & exmemFlush;
  assign bus.memwb_flush = nRST & memwbFlush;
  assign bus.halt        = haltQ;
  assign bus.err         = errQ;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Free-running wrap-around counters; HALTED cycles are not stalls
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if ((state != HALTED) && !pcEn) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (branchFire) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stallCnt;
  assign bus.flush_cnt = flushCnt;
`else
  assign bus.stall_cnt = CNT_W'(0);
  assign bus.flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;

  localparam int unsigned DRAIN   = 2;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CW      = 32;

  localparam logic [9:0] V_RUN    = 10'b1011110000;
  localparam logic [9:0] V_LW     = 10'b0001110100;
  localparam logic [9:0] V_IWAIT  = 10'b0011111000;
  localparam logic [9:0] V_DWAIT  = 10'b0000010001;
  localparam logic [9:0] V_BRANCH = 10'b1111111100;
  localparam logic [9:0] V_DRAIN  = 10'b0011111110;
  localparam logic [9:0] V_OFF    = 10'b0000000000;

  logic CLK = 1'b0;
  logic nRST;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(
    .DRAIN_CYCLES(DRAIN),
    .WAIT_TIMEOUT(TIMEOUT),
    .CNT_W(CW)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFail   = 0;

  // Model: remaining drain cycles, consecutive wait run, sticky flags, event counts
  bit          mHalted;
  int          mDrainLeft;
  int          mWaitRun;
  bit          mErr;
  logic [CW-1:0] mStall;
  logic [CW-1:0] mFlush;

  logic [9:0]    dutVec;
  logic [9:0]    seenVec;
  logic          seenHalt, seenErr;
  logic [CW-1:0] seenStall, seenFlush;

  assign dutVec = {bus.pc_en, bus.pc_sel, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] expVec(input bit ih, input bit dh, input bit dr,
                                        input bit sl, input bit br);
    if (mHalted)        return V_OFF;
    if (mDrainLeft > 0) return V_DRAIN;
    if (dr && !dh)      return V_DWAIT;
    if (br)             return V_BRANCH;
    if (sl)             return V_LW;
    if (!ih)            return V_IWAIT;
    return V_RUN;
  endfunction

  function automatic logic [CW-1:0] expStallCnt();
`ifdef PIPE_PERF_CNT_EN
    return mStall;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] expFlushCnt();
`ifdef PIPE_PERF_CNT_EN
    return mFlush;
`else
    return '0;
`endif
  endfunction

  task automatic modelReset();
    mHalted    = 1'b0;
    mDrainLeft = 0;
    mWaitRun   = 0;
    mErr       = 1'b0;
    mStall     = '0;
    mFlush     = '0;
  endtask

  // Called at a falling edge: drive, check the settled outputs, advance the model, return at next falling edge
  task automatic step(input bit ih, input bit dh, input bit dr, input bit sl, input bit br, input bit hm);
    bus.ihit         = ih;
    bus.dhit         = dh;
    bus.exmem_dreq   = dr;
    bus.stall_lw     = sl;
    bus.branch_taken = br;
    bus.halt_mem     = hm;
    #1;
    seenVec   = dutVec;
    seenHalt  = bus.halt;
    seenErr   = bus.err;
    seenStall = bus.stall_cnt;
    seenFlush = bus.flush_cnt;
    check("ctl", 64'(seenVec), 64'(expVec(ih, dh, dr, sl, br)));
    check("halt", 64'(seenHalt), 64'(mHalted));
    check("err", 64'(seenErr), 64'(mErr));
    check("stall_cnt", 64'(seenStall), 64'(expStallCnt()));
    check("flush_cnt", 64'(seenFlush), 64'(expFlushCnt()));
    @(posedge CLK);
    if (mHalted) begin
    end else if (mDrainLeft > 0) begin
      mStall++;
      mDrainLeft--;
      if (mDrainLeft == 0) mHalted = 1'b1;
    end else if (dr && !dh) begin
      mStall++;
      if (mWaitRun < 1000) mWaitRun++;
      if (mWaitRun >= int'(TIMEOUT) - 1) mErr = 1'b1;
    end else begin
      mWaitRun = 0;
      if (br) mFlush++;
      else if (sl || !ih) mStall++;
      if (hm) mDrainLeft = int'(DRAIN);
    end
    @(negedge CLK);
  endtask

  task automatic norm();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock
  task automatic resetPulse();
    #2 nRST = 1'b0;
    #1;
    check("rst_ctl", 64'(dutVec), 64'(V_OFF));
    check("rst_halt", 64'(bus.halt), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
    check("rst_flush_cnt", 64'(bus.flush_cnt), 64'(0));
    modelReset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic randStep();
    step($urandom_range(99) < 85, $urandom_range(99) < 50, $urandom_range(99) < 30,
         $urandom_range(99) < 15, $urandom_range(99) < 10, $urandom_range(99) < 3);
  endtask

  initial begin
    nRST             = 1'b0;
    bus.ihit         = 1'b1;
    bus.dhit         = 1'b0;
    bus.exmem_dreq   = 1'b0;
    bus.stall_lw     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.halt_mem     = 1'b0;
    modelReset();
    repeat (2) @(negedge CLK);
    check("por_ctl", 64'(dutVec), 64'(V_OFF));
    check("por_halt", 64'(bus.halt), 64'(0));
    check("por_err", 64'(bus.err), 64'(0));
    nRST = 1'b1;

    // Free-running after reset
    norm();
    check("run_ctl", 64'(seenVec), 64'(10'b1011110000));
    check("run_err", 64'(seenErr), 64'(0));

    // Single load-use bubble
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lw_ctl", 64'(seenVec), 64'(10'b0001110100));
    norm();
    check("lw_after", 64'(seenVec), 64'(10'b1011110000));

    // Three data-wait cycles then completion
    resetPulse();
    repeat (3) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("dwait_ctl", 64'(seenVec), 64'(10'b0000010001));
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("dwait_exit", 64'(seenVec), 64'(10'b1011110000));
`ifdef PIPE_PERF_CNT_EN
    check("dwait_stall_cnt", 64'(seenStall), 64'(3));
`endif

    // Branch overrides load-use and instruction miss
    resetPulse();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("br_ctl", 64'(seenVec), 64'(10'b1111111100));
    norm();
`ifdef PIPE_PERF_CNT_EN
    check("br_flush_cnt", 64'(seenFlush), 64'(1));
`endif

    // Halt drain then sticky halt until reset
    resetPulse();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("halt_req_ctl", 64'(seenVec), 64'(10'b1011110000));
    repeat (2) begin
      randStep();
      check("drain_ctl", 64'(seenVec), 64'(10'b0011111110));
      check("drain_halt", 64'(seenHalt), 64'(0));
    end
    repeat (5) begin
      randStep();
      check("halted_ctl", 64'(seenVec), 64'(0));
      check("halted_halt", 64'(seenHalt), 64'(1));
    end
    resetPulse();
    norm();
    check("unhalt", 64'(seenHalt), 64'(0));

    // Watchdog: err from the fourth consecutive wait cycle, sticky
    resetPulse();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("to_err", 64'(seenErr), 64'(i >= 4));
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("to_err_sticky", 64'(seenErr), 64'(1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    resetPulse();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(199) == 0) resetPulse();
      else randStep();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Consumes hazard-unit load-use requests, cache hit signals, EX-stage branch/jump resolution and MEM-stage halt detection. Drives per-latch enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable/select. Owns the halt drain sequence and the data-wait watchdog.

Parameters:
DRAIN_CYCLES, 2, cycles spent in HALTING before HALTED (latches drained to WB); legal range 1..15
WAIT_TIMEOUT, 64, consecutive DWAIT cycles before err asserts; legal range 2..255
CNT_W, 32, width of performance counters (optional feature)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  icache returned instruction this cycle
dhit  input  1  dcache completed access this cycle
exmem_dreq  input  1  EX/MEM holds a load or store (dREN|dWEN)
stall_lw  input  1  hazard unit load-use stall request
branch_taken  input  1  branch/jump resolved taken in EX
halt_mem  input  1  halt opcode present in EX/MEM
pc_en  output  1  PC register update enable
pc_sel  output  1  1 = load branch/jump target
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  latch zero-load (bubble), takes effect when paired enable=1
halt  output  1  processor halted, sticky
err  output  1  data-wait timeout, sticky
stall_cnt  output  CNT_W  cycles with pc_en=0 (optional feature)
flush_cnt  output  CNT_W  branch flush events (optional feature)

Behaviour:
- States: RUN, DWAIT, HALTING, HALTED. Async reset -> RUN, drain_cnt=0, wait_cnt=0, halt=0, err=0, counters=0.
- While nRST=0: all enables 0, all flushes 0, pc_sel=0.
- Per-cycle outputs, priority (highest first):
  1. HALTED: all enables 0, all flushes 0, halt=1.
  2. HALTING: pc_en=0; ifid/idex/exmem en=1 with flush=1; memwb_en=1 flush=0. drain_cnt increments; at DRAIN_CYCLES-1 -> HALTED next cycle.
  3. Data wait (exmem_dreq=1 and dhit=0): pc/ifid/idex/exmem en=0; memwb_en=1, memwb_flush=1. State DWAIT, wait_cnt increments (saturating); wait_cnt reaching WAIT_TIMEOUT-1 sets err (sticky, FSM stays waiting).
  4. Branch (branch_taken=1): pc_en=1, pc_sel=1; all latches enabled; ifid_flush=1, idex_flush=1. Overrides stall_lw and ihit=0 in the same cycle.
  5. Load-use (stall_lw=1): pc_en=0, ifid_en=0; idex_en=1 idex_flush=1; exmem/memwb advance.
  6. Instruction wait (ihit=0): pc_en=0; ifid_en=1 ifid_flush=1; others advance.
  7. Otherwise: all enables 1, flushes 0, pc_sel=0.
- DWAIT exits to RUN the cycle dhit=1; that cycle all latches advance (rules 4-7 then apply); wait_cnt clears.
- halt_mem=1 with no data wait: RUN -> HALTING next edge; halt_mem during data wait deferred until dhit.
- HALTED sticky until nRST; all inputs ignored in HALTING/HALTED.
- Reset asserted mid-DWAIT/HALTING: immediate return to RUN, counters cleared.

Optional Feature:
PIPE_PERF_CNT_EN: defined -> stall_cnt increments every cycle pc_en=0 outside HALTED (nRST=0 excluded), flush_cnt increments every cycle rule 4 fires; both wrap at 2^CNT_W, reset to 0. Undefined -> no counter registers; stall_cnt and flush_cnt tied to 0.

Test Plan:
- Reset release, ihit=1, no hazards -> all enables 1, flushes 0, halt=0, err=0 from first edge.
- stall_lw=1 one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; next cycle all enables 1.
- exmem_dreq=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles pc/ifid/idex/exmem en=0 with memwb_flush=1, 4th cycle all enables 1; with PIPE_PERF_CNT_EN stall_cnt=3.
- branch_taken=1 together with stall_lw=1 and ihit=0 -> pc_sel=1, pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1.
- halt_mem=1, DRAIN_CYCLES=2 -> 2 HALTING cycles (pc_en=0, flushes), then halt=1 and all enables 0 indefinitely; nRST pulse clears halt.
- WAIT_TIMEOUT=4, dhit held 0 for 6 cycles -> err=1 from 4th wait cycle, stays 1 after dhit returns; async nRST mid-wait clears err and state immediately.
